// File: rtl/icache_pkg.sv
// icache_pkg: FSM state encoding and geometry helpers shared by the instruction cache.
package icache_pkg;
  typedef enum logic [1:0] {IDLE, MISS_REQ, MISS_WAIT, RESP} state_e;
  function automatic int w_offset(int w_line);
    return $clog2(w_line / 8);
  endfunction
  function automatic int w_tag(int w_addr, int w_index, int w_line);
    return w_addr - w_index - w_offset(w_line);
  endfunction
endpackage

// File: rtl/icache_line_store.sv
// icache_line_store: data/tag arrays with sync write and async read, plus valid bits with a one-cycle clear.
module icache_line_store #(
  parameter int W_LINE  = 128,
  parameter int W_INDEX = 6,
  parameter int W_TAG   = 22
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear_all_i,
  input  logic               we_i,
  input  logic [W_INDEX-1:0] widx_i,
  input  logic [W_LINE-1:0]  wdata_i,
  input  logic [W_TAG-1:0]   wtag_i,
  input  logic [W_INDEX-1:0] ridx_i,
  output logic [W_LINE-1:0]  rdata_o,
  output logic [W_TAG-1:0]   rtag_o,
  output logic               rvalid_o
);
  localparam int N_SETS = 2 ** W_INDEX;
  logic [W_LINE-1:0] data_q [N_SETS];
  logic [W_TAG-1:0]  tag_q  [N_SETS];
  logic [N_SETS-1:0] valid_q;
  // Data and tag carry no reset so the arrays can map onto block RAM.
  always_ff @(posedge clk) begin
    if (we_i) begin
      data_q[widx_i] <= wdata_i;
      tag_q[widx_i]  <= wtag_i;
    end
  end
  always_ff @(posedge clk) begin
    if (reset || clear_all_i) valid_q <= '0;
    else if (we_i) valid_q[widx_i] <= 1'b1;
  end
  assign rdata_o  = data_q[ridx_i];
  assign rtag_o   = tag_q[ridx_i];
  assign rvalid_o = valid_q[ridx_i];
endmodule

// File: rtl/icache_dm.sv
// icache_dm: direct-mapped instruction cache with single-beat line refill, fetch abort and flush.
module icache_dm
  import icache_pkg::*;
#(
  parameter int W_ADDR  = 32,
  parameter int W_LINE  = 128,
  parameter int W_INDEX = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [W_ADDR-1:0] ifq_pc_in,
  input  logic              ifq_rd_en,
  input  logic              ifq_abort,
  output logic              ifq_ready,
  output logic [W_LINE-1:0] ifq_dout,
  output logic              ifq_dout_valid,
  input  logic              flush,
  output logic              mem_req,
  output logic [W_ADDR-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [W_LINE-1:0] mem_rdata,
  input  logic              mem_rvalid
);
  localparam int W_OFFSET = w_offset(W_LINE);
  localparam int W_TAG    = w_tag(W_ADDR, W_INDEX, W_LINE);
  localparam logic [W_ADDR-1:0] OFF_MASK = W_ADDR'((1 << W_OFFSET) - 1);
  state_e            state_q, state_d;
  logic [W_ADDR-1:0] mem_addr_q;
  logic [W_LINE-1:0] dout_q, rdata;
  logic [W_TAG-1:0]  rtag;
  logic              dvalid_q, aborted_q, flush_pend_q;
  logic              rvalid, hit, accept, we, clear_all, in_miss;
  always_comb begin
    ifq_ready = state_q == IDLE;
    mem_req   = state_q == MISS_REQ;
    in_miss   = state_q == MISS_REQ || state_q == MISS_WAIT;
    hit       = rvalid && rtag == ifq_pc_in[W_ADDR-1 -: W_TAG];
    accept    = ifq_ready && ifq_rd_en && !ifq_abort && !flush;
    we        = state_q == MISS_WAIT && mem_rvalid && !reset;
    // A pending flush lands on the RESP->IDLE edge so the fresh line is dropped too.
    clear_all = (state_q == IDLE && flush) || (state_q == RESP && (flush_pend_q || flush));
    state_d   = state_q;
    unique case (state_q)
      IDLE:      state_d = accept && !hit ? MISS_REQ : IDLE;
      MISS_REQ:  state_d = mem_ack ? MISS_WAIT : MISS_REQ;
      MISS_WAIT: state_d = mem_rvalid ? RESP : MISS_WAIT;
      default:   state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      mem_addr_q   <= '0;
      dout_q       <= '0;
      dvalid_q     <= 1'b0;
      aborted_q    <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      dvalid_q     <= (accept && hit) || (we && !aborted_q && !ifq_abort);
      dout_q       <= accept && hit ? rdata : we ? mem_rdata : dout_q;
      mem_addr_q   <= accept && !hit ? ifq_pc_in & ~OFF_MASK : mem_addr_q;
      aborted_q    <= state_q == RESP ? 1'b0 : aborted_q || (ifq_abort && in_miss);
      flush_pend_q <= state_q == RESP ? 1'b0 : flush_pend_q || (flush && state_q != IDLE);
    end
  end
  assign mem_addr       = mem_addr_q;
  assign ifq_dout       = dout_q;
  assign ifq_dout_valid = dvalid_q && !ifq_abort;
  icache_line_store #(.W_LINE(W_LINE), .W_INDEX(W_INDEX), .W_TAG(W_TAG)) u_store (
    .clk        (clk),
    .reset      (reset),
    .clear_all_i(clear_all),
    .we_i       (we),
    .widx_i     (mem_addr_q[W_OFFSET +: W_INDEX]),
    .wdata_i    (mem_rdata),
    .wtag_i     (mem_addr_q[W_ADDR-1 -: W_TAG]),
    .ridx_i     (ifq_pc_in[W_OFFSET +: W_INDEX]),
    .rdata_o    (rdata),
    .rtag_o     (rtag),
    .rvalid_o   (rvalid)
  );
endmodule

// File: tb/tb_icache_dm.sv
// tb_icache_dm: directed stimulus with an expected-response queue drained by a strobe monitor.
module tb_icache_dm;
  logic         clk = 0, reset = 1;
  logic [31:0]  ifq_pc_in = 0, mem_addr;
  logic         ifq_rd_en = 0, ifq_abort = 0, flush = 0, mem_ack = 0, mem_rvalid = 0;
  logic         ifq_ready, ifq_dout_valid, mem_req;
  logic [127:0] ifq_dout, mem_rdata = 0, mon_exp;
  logic [127:0] exp_q[$];
  int n_cmp = 0, n_err = 0;
  localparam logic [127:0] DA = {4{32'hAAAA_AAAA}}, DA2 = {4{32'h1234_5678}}, DB = {4{32'hBBBB_BBBB}};
  localparam logic [127:0] DC = {4{32'hCCCC_CCCC}}, D0 = {4{32'h0000_D000}}, D1 = {4{32'h1111_D111}};
  localparam logic [127:0] D2 = {4{32'h2222_D222}}, DE = {4{32'hEEEE_EEEE}};

  icache_dm dut (
    .clk(clk), .reset(reset), .ifq_pc_in(ifq_pc_in), .ifq_rd_en(ifq_rd_en), .ifq_abort(ifq_abort),
    .ifq_ready(ifq_ready), .ifq_dout(ifq_dout), .ifq_dout_valid(ifq_dout_valid), .flush(flush),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset && ifq_dout_valid) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_strobe: got %h want no strobe", ifq_dout);
      end else begin
        mon_exp = exp_q.pop_front();
        if (ifq_dout !== mon_exp) begin
          n_err++;
          $display("FAIL strobe_data: got %h want %h", ifq_dout, mon_exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic do_miss(input logic [31:0] pc, input logic [127:0] d, input bit ab, input bit fl);
    if (!ab) exp_q.push_back(d);
    ifq_pc_in = pc; ifq_rd_en = 1; tick(); ifq_rd_en = 0;
    chk("miss_ready", ifq_ready, 0);
    chk("mem_req", mem_req, 1);
    chk("mem_addr", mem_addr, pc & ~32'hF);
    tick(); tick();
    chk("req_held", mem_req, 1);
    mem_ack = 1; tick(); mem_ack = 0;
    chk("req_drop", mem_req, 0);
    ifq_abort = ab; flush = fl; tick(); ifq_abort = 0; flush = 0; tick();
    mem_rvalid = 1; mem_rdata = d; tick(); mem_rvalid = 0;
    chk("resp_valid", ifq_dout_valid, !ab);
    chk("resp_dout", ifq_dout, d);
    tick();
    chk("idle_ready", ifq_ready, 1);
  endtask

  task automatic do_hit(input logic [31:0] pc, input logic [127:0] d);
    exp_q.push_back(d);
    ifq_pc_in = pc; ifq_rd_en = 1; tick(); ifq_rd_en = 0;
    chk("hit_ready", ifq_ready, 1);
    chk("hit_valid", ifq_dout_valid, 1);
    tick();
  endtask

  initial begin
    repeat (3) tick();
    reset = 0; tick();
    chk("rst_ready", ifq_ready, 1);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_dout", ifq_dout, 0);
    chk("rst_valid", ifq_dout_valid, 0);
    // 1: cold miss then hit on another offset of the same line
    do_miss(32'h40, DA, 0, 0);
    do_hit(32'h44, DA);
    // 2: conflicting tag on index 4 evicts 0x40
    do_miss(32'h440, DB, 0, 0);
    do_miss(32'h40, DA2, 0, 0);
    // 3: aborted refill still installs the line
    do_miss(32'h80, DC, 1, 0);
    do_hit(32'h80, DC);
    // 4: flush in IDLE, then flush during a miss
    do_miss(32'h00, D0, 0, 0);
    do_miss(32'h10, D1, 0, 0);
    flush = 1; ifq_pc_in = 32'h00; ifq_rd_en = 1; tick(); flush = 0; ifq_rd_en = 0;
    chk("flush_noaccept", ifq_dout_valid, 0);
    chk("flush_ready", ifq_ready, 1);
    tick();
    do_miss(32'h00, D0, 0, 0);
    do_miss(32'h10, D1, 0, 0);
    do_miss(32'h20, D2, 0, 1);
    do_miss(32'h20, D2, 0, 0);
    do_miss(32'h00, D0, 0, 0);
    do_miss(32'h10, D1, 0, 0);
    // 5: back-to-back hits, then abort on a second response cycle
    exp_q.push_back(D0); exp_q.push_back(D1); exp_q.push_back(D2);
    ifq_rd_en = 1;
    ifq_pc_in = 32'h00; tick();
    chk("b2b_v0", ifq_dout_valid, 1); chk("b2b_d0", ifq_dout, D0);
    ifq_pc_in = 32'h10; tick();
    chk("b2b_v1", ifq_dout_valid, 1); chk("b2b_d1", ifq_dout, D1);
    ifq_pc_in = 32'h20; tick();
    chk("b2b_v2", ifq_dout_valid, 1); chk("b2b_d2", ifq_dout, D2);
    ifq_rd_en = 0; tick();
    exp_q.push_back(D0); exp_q.push_back(D2);
    ifq_rd_en = 1; ifq_pc_in = 32'h00; tick();
    ifq_pc_in = 32'h10; tick();
    ifq_rd_en = 0; ifq_abort = 1; #1;
    chk("abort_strobe", ifq_dout_valid, 0);
    tick(); ifq_abort = 0;
    ifq_rd_en = 1; ifq_pc_in = 32'h20; tick(); ifq_rd_en = 0;
    chk("after_abort_v", ifq_dout_valid, 1);
    chk("after_abort_d", ifq_dout, D2);
    tick();
    // 6: reset while waiting for refill data
    ifq_pc_in = 32'hC0; ifq_rd_en = 1; tick(); ifq_rd_en = 0;
    tick();
    mem_ack = 1; tick(); mem_ack = 0;
    reset = 1; tick(); reset = 0;
    mem_rvalid = 1; mem_rdata = DE; tick(); mem_rvalid = 0;
    chk("rst_mid_ready", ifq_ready, 1);
    chk("rst_mid_valid", ifq_dout_valid, 0);
    chk("rst_mid_req", mem_req, 0);
    tick();
    do_miss(32'hC0, DE, 0, 0);
    repeat (3) tick();
    chk("queue_empty", 128'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
